// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: a WIDTH-bit operation is split into CHUNK-bit ripple
// slices, one slice per stage, with the inter-slice carry registered between stages.
module pipe_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             carryin,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);
   localparam int NSTAGE = WIDTH / CHUNK;

   // Returns {carry into the slice MSB, carry out of the slice, slice sum}.
   function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b,
                                                  input logic             ci);
      logic [CHUNK-1:0] s;
      logic             c;
      logic             c_top;
      s     = '0;
      c     = ci;
      c_top = ci;
      for (int i = 0; i < CHUNK; i++) begin
         c_top = c;
         s[i]  = a[i] ^ b[i] ^ c;
         c     = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      return {c_top, c, s};
   endfunction

   // Operands are kept right-shifted so each stage always consumes the low CHUNK bits;
   // finished sum slices enter from the top and reach their final position in the last stage.
   logic             v_q  [NSTAGE];
   logic             c_q  [NSTAGE];
   logic             mc_q [NSTAGE];
   logic [WIDTH-1:0] a_q  [NSTAGE];
   logic [WIDTH-1:0] b_q  [NSTAGE];
   logic [WIDTH-1:0] s_q  [NSTAGE];
   logic             rdy  [NSTAGE];

   always_comb begin
      rdy[NSTAGE-1] = ~v_q[NSTAGE-1] | out_ready;
      for (int k = NSTAGE - 2; k >= 0; k--) begin
         rdy[k] = ~v_q[k] | rdy[k+1];
      end
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK+1:0] r;

      if (k == 0) begin : g_head
         assign a_in = x;
         assign b_in = sub ? ~y : y;
         assign c_in = sub | carryin;
         assign s_in = '0;
         assign v_in = in_valid;
      end else begin : g_tail
         assign a_in = a_q[k-1];
         assign b_in = b_q[k-1];
         assign c_in = c_q[k-1];
         assign s_in = s_q[k-1];
         assign v_in = v_q[k-1];
      end

      assign r = slice_add(a_in[CHUNK-1:0], b_in[CHUNK-1:0], c_in);

      always_ff @(posedge clk) begin
         if (reset) begin
            // NOTE: datapath fields are cleared too, so sum/carryout/overflow read 0 after reset.
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            mc_q[k] <= 1'b0;
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            s_q[k]  <= '0;
         end else if (rdy[k]) begin
            v_q[k] <= v_in;
            if (v_in) begin
               a_q[k]  <= a_in >> CHUNK;
               b_q[k]  <= b_in >> CHUNK;
               s_q[k]  <= WIDTH'({r[CHUNK-1:0], s_in} >> CHUNK);
               c_q[k]  <= r[CHUNK];
               mc_q[k] <= r[CHUNK+1];
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[NSTAGE-1];
   assign sum       = s_q[NSTAGE-1];
   assign carryout  = c_q[NSTAGE-1];
   assign overflow  = c_q[NSTAGE-1] ^ mc_q[NSTAGE-1];

endmodule
